// File: rtl/counter_ticker_pkg.sv
// counter_ticker_pkg
//   Shared types and constants for the counter_ticker rate generator.
//   - state_t     : FSM state encoding (IDLE, RUN, DONE)
//   - MODE_*      : values of the mode input (continuous / burst)
//   - ctrl_t      : shared control bundle carrying clock and reset
//   - ctrl_clock / ctrl_reset : accessors for the control-bundle fields
package counter_ticker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_BURST      = 1'b1;

  // Shared control bundle: single rising-edge clock plus synchronous,
  // active-high reset.
  typedef struct packed {
    logic clk;
    logic rst;
  } ctrl_t;

  function automatic logic ctrl_clock(input ctrl_t c);
    return c.clk;
  endfunction

  function automatic logic ctrl_reset(input ctrl_t c);
    return c.rst;
  endfunction

endpackage

// File: rtl/counter_ticker.sv
// counter_ticker
//   Programmable rate generator. Emits one-cycle tick pulses every `per`
//   clocks, either continuously (until stop) or as a burst of `count` ticks,
//   with a start/stop handshake reporting busy/done.
// Ports:
//   ctrl      in   control bundle (clock, synchronous active-high reset)
//   start     in   launch request, accepted in IDLE or DONE when stop = 0
//   stop      in   abort request (wins over start)
//   mode      in   0 = continuous, 1 = burst (latched on accepted start)
//   period    in   tick spacing in cycles, 0 treated as 1 (latched)
//   count     in   burst length in ticks (latched, burst mode only)
//   tick      out  one-cycle pulse, drives the downstream enable
//   busy      out  high while in RUN
//   done      out  one-cycle pulse on completion or abort
//   remaining out  burst ticks not yet issued
module counter_ticker
  import counter_ticker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  ctrl_t            ctrl,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  logic             clk_s;
  logic             rst_s;

  state_t           state_r;
  state_t           state_s;
  logic             mode_r;
  logic             mode_s;
  logic [WIDTH-1:0] per_r;
  logic [WIDTH-1:0] per_s;
  logic [WIDTH-1:0] phase_r;
  logic [WIDTH-1:0] phase_s;
  logic [WIDTH-1:0] remaining_r;
  logic [WIDTH-1:0] remaining_s;
  logic             tick_r;
  logic             busy_r;
  logic             done_r;

  logic             cur_tick_s;
  logic             accept_s;
  logic [WIDTH-1:0] per_load_s;

  assign clk_s = ctrl_clock(ctrl);
  assign rst_s = ctrl_reset(ctrl);

  // Decode the tick of the current cycle, start acceptance and the loaded period.
  always_comb begin
    cur_tick_s = (state_r == RUN) && (phase_r == ZERO);
    accept_s   = start && !stop && ((state_r == IDLE) || (state_r == DONE));
    if (period == ZERO) begin
      per_load_s = ONE;
    end else begin
      per_load_s = period;
    end
  end

  // Next-state logic for the FSM, phase counter and remaining counter.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    per_s       = per_r;
    phase_s     = phase_r;
    remaining_s = remaining_r;

    if (accept_s) begin
      // Start is only honoured from IDLE/DONE, so latched values are
      // untouched by a start seen during RUN.
      mode_s  = mode;
      per_s   = per_load_s;
      phase_s = per_load_s - ONE;
      if (mode == MODE_BURST) begin
        remaining_s = count;
        if (count == ZERO) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end else begin
        remaining_s = ZERO;
        state_s     = RUN;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (cur_tick_s) begin
            phase_s = per_r - ONE;
            if (mode_r == MODE_CONTINUOUS) begin
              remaining_s = remaining_r;
            end else if (remaining_r != ZERO) begin
              remaining_s = remaining_r - ONE;
              // The tick issued with remaining == 1 is the last one.
              if (remaining_r == ONE) begin
                state_s = DONE;
              end else begin
                state_s = RUN;
              end
            end else begin
              remaining_s = remaining_r;
            end
          end else begin
            phase_s = phase_r - ONE;
          end
          // Stop still lets the tick already decoded this cycle go out
          // (and its decrement land), then ends the run.
          if (stop) begin
            state_s = DONE;
          end else begin
            state_s = state_s;
          end
        end
        DONE: begin
          state_s     = IDLE;
          remaining_s = ZERO;
        end
        default: begin
          state_s     = IDLE;
          remaining_s = ZERO;
          phase_s     = ZERO;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset; outputs are
  // registered copies of the decode of the next state.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_r     <= IDLE;
      mode_r      <= MODE_CONTINUOUS;
      per_r       <= ONE;
      phase_r     <= ZERO;
      remaining_r <= ZERO;
      tick_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      per_r       <= per_s;
      phase_r     <= phase_s;
      remaining_r <= remaining_s;
      tick_r      <= (state_s == RUN) && (phase_s == ZERO);
      busy_r      <= (state_s == RUN);
      done_r      <= (state_s == DONE);
    end
  end

  assign tick      = tick_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = remaining_r;

endmodule

// File: tb/tb_counter_ticker.sv
module tb_counter_ticker;
  import counter_ticker_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  ctrl_t            ctrl;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  int checks;
  int errors;

  assign ctrl = '{clk: clk, rst: rst};

  counter_ticker #(.WIDTH(WIDTH)) dut (
    .ctrl      (ctrl),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .period    (period),
    .count     (count),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    logic [10:0] exp;
    rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b1; period = 8'd1; count = 8'd4;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 2) begin
        rst = 1'b0;
        start = 1'b0;
      end
      obs = {tick, busy, done, remaining};
      exp = {1'b0, 1'b0, 1'b0, 8'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_continuous();
    logic [10:0] obs;
    logic [10:0] exp;
    mode = 1'b0; period = 8'd3; count = 8'd7; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      obs = {tick, busy, done, remaining};
      exp = {(c == 3 || c == 6 || c == 9), (c >= 1 && c <= 10), (c == 11), 8'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL continuous cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
      start = 1'b0;
      stop  = (c == 10);
    end
    stop = 1'b0;
  endtask

  task automatic test_burst();
    logic [10:0] obs;
    logic [10:0] exp;
    logic [7:0]  rem;
    mode = 1'b1; period = 8'd1; count = 8'd4; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      rem = (c <= 4) ? 8'(5 - c) : 8'd0;
      obs = {tick, busy, done, remaining};
      exp = {(c <= 4), (c <= 4), (c == 5), rem};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL burst cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_period_zero();
    logic [10:0] obs;
    logic [10:0] exp;
    logic [7:0]  rem;
    mode = 1'b1; period = 8'd0; count = 8'd3; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
      rem = (c <= 3) ? 8'(4 - c) : 8'd0;
      obs = {tick, busy, done, remaining};
      exp = {(c <= 3), (c <= 3), (c == 4), rem};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL period_zero cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_count_zero();
    logic [10:0] obs;
    logic [10:0] exp;
    mode = 1'b1; period = 8'd5; count = 8'd0; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0;
      obs = {tick, busy, done, remaining};
      exp = {1'b0, 1'b0, (c == 1), 8'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL count_zero cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_start_with_stop();
    logic [10:0] obs;
    logic [10:0] exp;
    mode = 1'b1; period = 8'd1; count = 8'd3; start = 1'b1; stop = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) begin
        start = 1'b0;
        stop  = 1'b0;
      end
      obs = {tick, busy, done, remaining};
      exp = {1'b0, 1'b0, 1'b0, 8'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL start_with_stop cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs;
    logic [10:0] exp;
    logic [7:0]  rem;
    mode = 1'b1; period = 8'd2; count = 8'd2; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c <= 2)       rem = 8'd2;
      else if (c <= 4)  rem = 8'd1;
      else if (c == 5)  rem = 8'd0;
      else if (c <= 10) rem = 8'd2;
      else if (c <= 15) rem = 8'd1;
      else              rem = 8'd0;
      obs = {tick, busy, done, remaining};
      exp = {(c == 2 || c == 4 || c == 10 || c == 15),
             ((c >= 1 && c <= 4) || (c >= 6 && c <= 15)),
             (c == 5 || c == 16), rem};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
      // Restart in the DONE cycle; a start during RUN must be ignored.
      if (c == 5) begin
        start = 1'b1; mode = 1'b1; period = 8'd5; count = 8'd2;
      end else if (c == 7) begin
        start = 1'b1; mode = 1'b0; period = 8'd1; count = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [10:0] obs;
    logic [10:0] exp;
    logic [7:0]  rem;
    mode = 1'b1; period = 8'd2; count = 8'd8; start = 1'b1; stop = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      if (c <= 2)      rem = 8'd8;
      else if (c <= 4) rem = 8'd7;
      else if (c <= 6) rem = 8'd6;
      else if (c == 7) rem = 8'd5;
      else             rem = 8'd0;
      obs = {tick, busy, done, remaining};
      exp = {(c == 2 || c == 4 || c == 6), (c <= 7), 1'b0, rem};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got t/b/d/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 c, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
      rst = (c == 7);
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; period = 8'd0; count = 8'd0;
    test_reset();
    idle_gap();
    test_continuous();
    idle_gap();
    test_burst();
    idle_gap();
    test_period_zero();
    idle_gap();
    test_count_zero();
    idle_gap();
    test_start_with_stop();
    idle_gap();
    test_back_to_back();
    idle_gap();
    test_mid_reset();
    idle_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ticker.md
# counter_ticker

Programmable rate generator that drives the `enable` input of the load/enable counter stage directly downstream. It emits single-cycle `tick` pulses every `period` clocks, either continuously or as a burst of `count` ticks. It exposes a start/stop handshake with `busy`/`done` status, so a sequencer can launch a burst and wait for completion.

## Interface
- `WIDTH`, 8: width of `period`, `count`, `remaining` and the internal counters.
- `ctrl`  input  control bundle  shared control bundle; its Clock field is the single clock (rising edge), its Reset field is the reset, synchronous and active-high. These come first.
- `start`  input  1  launch request; sampled each edge.
- `stop`  input  1  abort request.
- `mode`  input  1  0 = continuous, 1 = burst; latched on accepted start.
- `period`  input  WIDTH  ticks every `period` cycles; 0 is treated as 1; latched on accepted start.
- `count`  input  WIDTH  burst length in ticks; latched on accepted start; ignored in continuous mode.
- `tick`  output  1  one-cycle pulse; connects to the downstream `enable`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse on completion or abort.
- `remaining`  output  WIDTH  burst ticks not yet issued; 0 in continuous mode and in IDLE.

## Operation
- **States:**
  - IDLE: `busy`, `tick` and `done` are 0.
  - RUN: `busy` is 1.
  - DONE: lasts exactly one cycle; `done` is 1 and `busy` is 0.
- **Accepting start:** start is accepted in IDLE or DONE when `stop` = 0. On acceptance, load:
  - `per` = max(`period`, 1)
  - `phase` = `per` − 1
  - `remaining` = `count` (burst) or 0 (continuous)
  - `mode` is latched.
  - Next state is RUN, except burst with `count` = 0, which goes straight to DONE with no ticks.
- **Ignored start:** `start` in RUN is ignored; latched values are not changed.
- **Tick generation:** `tick` = (state == RUN) && (`phase` == 0). It is decoded from registers only, with no combinational path from inputs.
- **Phase counter in RUN:** if `phase` == 0, reload `per` − 1; otherwise decrement.
- **Burst mode:** on each tick, `remaining` decrements. The tick with `remaining` == 1 is the last one, and the next state is DONE.
- **Continuous mode:** stays in RUN until `stop`.
- **Stop in RUN:** next state is DONE. A tick already decoded in the stop cycle is still issued, and no further ticks follow. `remaining` freezes at its value after that cycle.
- **Stop in IDLE or DONE:** no effect. `stop` together with `start` in IDLE or DONE: `stop` wins and `start` is dropped.
- **DONE → IDLE:** the next state is IDLE unless a start is accepted. On entering IDLE, `remaining` clears to 0.
- **Arithmetic:** all counters are unsigned WIDTH bits. `period` = 2^WIDTH−1 and `count` = 2^WIDTH−1 are legal. No wrap-around occurs, because decrements are gated by the zero tests.

## Timing
- **Reset:** synchronous. The edge with Reset = 1 forces IDLE, `tick` = 0, `busy` = 0, `done` = 0, `remaining` = 0, `phase` = 0. Reset mid-burst aborts silently, with no `done` pulse. Reset overrides `start` and `stop`.
- **Cycle numbering:** the cycle in which an accepted `start` is high is cycle 0.
  - `busy` is 1 from cycle 1.
  - First tick in cycle P, then ticks in cycles 2P, 3P, …, where P = `per`.
  - P = 1 gives a tick every cycle from cycle 1.
- **Burst of C ≥ 1:** last tick in cycle C·P. `done` = 1 and `busy` = 0 in cycle C·P+1; IDLE from cycle C·P+2.
- **Burst of C = 0:** `done` in cycle 1; `busy` never rises.
- **Stop asserted in cycle s (RUN):** `done` in cycle s+1; `tick` = 0 from cycle s+1.
- **Back-to-back runs:** `start` accepted during the DONE cycle gives `busy` high again in the next cycle. There is no idle gap.

## Structure
- **Shared package:** state enum (IDLE, RUN, DONE) and mode constants (MODE_CONTINUOUS = 0, MODE_BURST = 1). Control-bundle field access uses the existing shared control-bundle accessors.
- **Single module, no sub-module:** the phase counter and remaining counter are inline registers. The FSM is one registered state plus next-state logic.

## Test plan
- **Reset:** hold Reset 2 cycles with `start` = 1 → all outputs 0; no RUN entry.
- **Continuous:** `period` = 3, `mode` = 0, start in cycle 0, stop in cycle 10 → ticks in cycles 3, 6, 9; `done` in cycle 11; `busy` in cycles 1–10 only.
- **Burst:** `period` = 1, `count` = 4 → ticks in cycles 1–4; `remaining` goes 4, 3, 2, 1, 0; `done` in cycle 5.
- **Edge values:**
  - `period` = 0 behaves as 1.
  - `count` = 0 gives `done` in cycle 1 and no tick.
  - `start` with `stop` in IDLE → no response.
- **Back-to-back:** burst `count` = 2, `period` = 2, restart in the DONE cycle with `period` = 5 → second-run ticks 5 and 10 cycles after the restart cycle. A `start` during RUN does not alter `per`.
- **Mid-burst reset:** `count` = 8, `period` = 2, Reset in cycle 7 → no `done` pulse; `tick` stays 0; `remaining` = 0 next cycle.
